// File: rtl/mlp_axis_pkg.sv
// Shared widths, word type and sizing helper for the MLP AXI-Stream output stage.
package mlp_axis_pkg;

  localparam int C_M_AXIS_TDATA_WIDTH_DEF = 32;
  localparam int C_M_AXIS_TSTRB_WIDTH_DEF = C_M_AXIS_TDATA_WIDTH_DEF / 8;

  typedef logic [C_M_AXIS_TDATA_WIDTH_DEF-1:0] mlp_word_t;

  // Bits needed to index n items; never less than 1 so a 1-entry range still has a signal.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout shows the head whenever !empty.
module sync_fifo
  import mlp_axis_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en,
  input  logic [WIDTH-1:0]                   din,
  input  logic                               rd_en,
  output logic [WIDTH-1:0]                   dout,
  output logic                               full,
  output logic                               empty,
  output logic [clog2_min1(DEPTH+1)-1:0]     count
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = clog2_min1(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             wr_ok, rd_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // Full is judged on the registered count, so a same-cycle read never frees a slot for the write.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_master_mlp_out.sv
// MLP result stream out: FIFO buffer, AXIS output register, beat counter for TLAST, status flags.
module axis_master_mlp_out
  import mlp_axis_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = C_M_AXIS_TDATA_WIDTH_DEF,
  parameter int C_FIFO_DEPTH         = 16,
  parameter int C_PKT_LEN            = 10
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESET,
  input  logic                                pi_mlp_data_valid,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     pi_mlp_data,
  output logic                                po_mlp_ready,
  output logic                                po_overflow,
  output logic                                po_pkt_done,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY
);

  localparam int W  = C_M_AXIS_TDATA_WIDTH;
  localparam int BW = clog2_min1(C_PKT_LEN);
  localparam int CW = clog2_min1(C_FIFO_DEPTH + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(C_PKT_LEN - 1);

  if (C_FIFO_DEPTH < 2 || (C_FIFO_DEPTH & (C_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("C_FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (C_PKT_LEN < 1) begin : g_bad_pkt
    $error("C_PKT_LEN must be at least 1");
  end

  logic          fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [W-1:0]  fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          unused_count;

  logic          out_vld;
  logic [W-1:0]  out_data;
  logic [BW-1:0] beat;
  logic          hs;

  assign po_mlp_ready = ~fifo_full & ~M_AXIS_ARESET;
  assign fifo_wr      = pi_mlp_data_valid & po_mlp_ready;
  assign hs           = out_vld & M_AXIS_TREADY;
  // Refill the output register when it is empty or being emptied this cycle.
  assign fifo_rd      = ~fifo_empty & (~out_vld | hs);
  assign unused_count = ^fifo_count;

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk   (M_AXIS_ACLK),
    .rst   (M_AXIS_ARESET),
    .wr_en (fifo_wr),
    .din   (pi_mlp_data),
    .rd_en (fifo_rd),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (fifo_rd) begin
      out_vld  <= 1'b1;
      out_data <= fifo_dout;
    end else if (hs) begin
      out_vld  <= 1'b0;
    end
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      beat        <= '0;
      po_pkt_done <= 1'b0;
      po_overflow <= 1'b0;
    end else begin
      po_pkt_done <= hs & M_AXIS_TLAST;
      if (hs) beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      if (pi_mlp_data_valid & fifo_full) po_overflow <= 1'b1;
    end
  end

  assign M_AXIS_TVALID = out_vld;
  assign M_AXIS_TDATA  = out_data;
  assign M_AXIS_TSTRB  = '1;
  assign M_AXIS_TLAST  = out_vld & (beat == LAST_BEAT);

endmodule

// File: tb/tb_axis_master_mlp_out.sv
// Randomized bench for axis_master_mlp_out against a queue-based scoreboard of accepted words.
module tb_axis_master_mlp_out;
  import mlp_axis_pkg::*;

  localparam int W   = 32;
  localparam int PKT = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_vld;
  mlp_word_t       in_data;
  logic            ready, ovf, done;
  logic            tvalid, tlast, tready;
  logic [W-1:0]    tdata;
  logic [W/8-1:0]  tstrb;

  always #5 clk = ~clk;

  axis_master_mlp_out #(
    .C_M_AXIS_TDATA_WIDTH (W),
    .C_FIFO_DEPTH         (16),
    .C_PKT_LEN            (PKT)
  ) dut (
    .M_AXIS_ACLK       (clk),
    .M_AXIS_ARESET     (rst),
    .pi_mlp_data_valid (in_vld),
    .pi_mlp_data       (in_data),
    .po_mlp_ready      (ready),
    .po_overflow       (ovf),
    .po_pkt_done       (done),
    .M_AXIS_TVALID     (tvalid),
    .M_AXIS_TDATA      (tdata),
    .M_AXIS_TSTRB      (tstrb),
    .M_AXIS_TLAST      (tlast),
    .M_AXIS_TREADY     (tready)
  );

  int        n_vec = 0, n_err = 0;
  mlp_word_t sb[$];
  int        beat = 0;
  logic      exp_done = 1'b0, exp_ovf = 1'b0;
  logic      prev_stall = 1'b0, prev_last = 1'b0;
  logic [W-1:0] prev_data = '0;
  int        cyc = 0, n_hs = 0, n_done = 0, n_acc = 0;
  int        first_hs = -1, last_hs = -1, first_vld = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called between edges: check what the DUT presents now, then drive the next cycle.
  task automatic step(input logic v, input mlp_word_t d, input logic rdy);
    logic hs;
    chk("pkt_done", done, exp_done);
    chk("overflow", ovf, exp_ovf);
    chk("tstrb", tstrb, 4'hF);
    if (prev_stall) begin
      chk("hold_vld", tvalid, 1'b1);
      chk("hold_data", tdata, prev_data);
      chk("hold_last", tlast, prev_last);
    end
    if (sb.size() == 0) chk("vld_idle", tvalid, 1'b0);
    if (done) n_done++;
    if (tvalid && first_vld < 0) first_vld = cyc;
    hs = tvalid && rdy && (sb.size() != 0);
    exp_done = 1'b0;
    if (hs) begin
      chk("tdata", tdata, sb.pop_front());
      chk("tlast", tlast, beat == PKT - 1);
      exp_done = (beat == PKT - 1);
      beat = (beat + 1) % PKT;
      n_hs++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
    end
    prev_stall = tvalid && !rdy;
    prev_data  = tdata;
    prev_last  = tlast;
    if (v && !ready) exp_ovf = 1'b1;
    if (v && ready) begin
      sb.push_back(d);
      n_acc++;
    end
    in_vld  = v;
    in_data = d;
    tready  = rdy;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    in_vld = 1'b0;
    tready = 1'b0;
    #1 chk("rst_ready", ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_tdata", tdata, 32'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    #1 chk("ready_after_rst", ready, 1'b1);
    sb.delete();
    beat = 0;
    exp_done = 1'b0;
    exp_ovf = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (sb.size() != 0 && b < 300) begin
      step(1'b0, '0, 1'b1);
      b++;
    end
    step(1'b0, '0, 1'b1);
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    int c0, h0, sent, k;
    logic v;
    rst = 1'b1; in_vld = 1'b0; in_data = '0; tready = 1'b0;
    @(negedge clk);
    do_reset();

    // Basic packet with ramp data and fill latency
    n_done = 0; first_vld = -1; c0 = cyc;
    for (int i = 0; i < 10; i++) step(1'b1, mlp_word_t'(3 + 11 * i), 1'b1);
    drain();
    chk("basic_latency", first_vld - c0, 2);
    chk("basic_done_cnt", n_done, 1);

    // Backpressure: TVALID held with TREADY low
    step(1'b1, 32'hA0A0_0001, 1'b0);
    step(1'b1, 32'hA0A0_0002, 1'b0);
    step(1'b1, 32'hA0A0_0003, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
    chk("bp_vld", tvalid, 1'b1);
    drain();

    // Fill to capacity, overflow, refused write while a read happens
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 18; i++) step(1'b1, $urandom, 1'b0);
    chk("full_accepted", n_acc, 17);
    chk("full_ready", ready, 1'b0);
    h0 = n_hs;
    step(1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("ovf_flag", ovf, 1'b1);
    drain();
    chk("full_drained", n_hs - h0, 17);

    // Streaming, one beat per cycle
    do_reset();
    n_done = 0; first_hs = -1;
    for (int i = 0; i < 30; i++) step(1'b1, $urandom, 1'b1);
    drain();
    chk("stream_rate", last_hs - first_hs, 29);
    chk("stream_done_cnt", n_done, 3);

    // Random gaps and random TREADY
    do_reset();
    n_done = 0; sent = 0; k = 0;
    while (sent < 200 && k < 4000) begin
      v = ($urandom_range(2) != 0) && ready;
      step(v, $urandom, 1'($urandom_range(1)));
      if (v) sent++;
      k++;
    end
    chk("rand_sent", sent, 200);
    drain();
    chk("rand_done_cnt", n_done, 20);
    chk("rand_ovf", ovf, 1'b0);

    // Reset in the middle of a packet
    h0 = n_hs; k = 0;
    while (n_hs - h0 < 4 && k < 50) begin
      step(k < 8, mlp_word_t'(32'h100 + k), 1'b1);
      k++;
    end
    chk("mid_beats", n_hs - h0, 4);
    do_reset();
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    n_done = 0;
    for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b1);
    drain();
    chk("mid_done_cnt", n_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_master_mlp_out.md
Name: axis_master_mlp_out

Overview:
Output stage of the MLP accelerator, directly downstream of the MLP core. It buffers result words produced by the core in a FIFO and streams them out over an AXI4-Stream master port to the DMA. TLAST marks the end of each result vector of C_PKT_LEN words. It is the counterpart of the AXI-Stream slave input stage that feeds the core.

Parameters:
C_M_AXIS_TDATA_WIDTH, 32, width of result words and TDATA.
C_FIFO_DEPTH, 16, FIFO depth in words; must be a power of 2 and at least 2.
C_PKT_LEN, 10, beats per packet (one MLP output vector); TLAST is on beat C_PKT_LEN-1; must be at least 1.

Ports:
M_AXIS_ACLK  in  1  single clock; all logic on its rising edge.
M_AXIS_ARESET  in  1  synchronous, active-high reset.
pi_mlp_data_valid  in  1  core presents a result word this cycle.
pi_mlp_data  in  C_M_AXIS_TDATA_WIDTH  result word.
po_mlp_ready  out  1  FIFO can accept a word; equals not-full.
po_overflow  out  1  sticky: a word arrived while the FIFO was full.
po_pkt_done  out  1  one-cycle pulse on the handshake of a TLAST beat.
M_AXIS_TVALID  out  1  AXIS valid.
M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  AXIS data.
M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  always all ones.
M_AXIS_TLAST  out  1  last beat of packet.
M_AXIS_TREADY  in  1  downstream ready.

Behaviour:
- Reset, synchronous and active-high, sampled on the M_AXIS_ACLK edge.
  - Clears FIFO pointers and count, output register, beat counter, po_overflow and po_pkt_done.
  - Values while reset: TVALID=0, TLAST=0, TDATA=0, po_mlp_ready=0.
  - po_mlp_ready=1 from the first cycle after reset deasserts.
  - Reset mid-packet discards all buffered and in-flight words; the next packet starts at beat 0.
- Write side:
  - A word is written on an edge where pi_mlp_data_valid=1 and po_mlp_ready=1.
  - If pi_mlp_data_valid=1 while full, the word is dropped, FIFO contents are unchanged, and po_overflow is set until reset.
  - A write is refused when full even if a read happens in the same cycle.
- Output register (FIFO to AXIS):
  - The register loads the FIFO head when it is empty, or when a handshake (TVALID and TREADY) happens in that cycle and the FIFO is non-empty.
  - TVALID=1 whenever the register holds a word.
  - Latency: a word written at edge N, into an empty FIFO and empty register, gives TVALID=1 after edge N+1.
  - With the FIFO non-empty and TREADY held high, the stage sustains one beat per cycle.
- AXIS rules:
  - Once TVALID=1, TVALID, TDATA and TLAST hold until the handshake.
  - TVALID never drops without a handshake.
  - TVALID does not depend combinationally on TREADY.
- Beat counter, width clog2(C_PKT_LEN) with a minimum of 1:
  - Holds the index of the beat currently presented.
  - Increments on each handshake and wraps to 0 after beat C_PKT_LEN-1.
  - TLAST = TVALID and (count == C_PKT_LEN-1).
  - With C_PKT_LEN=1, every beat has TLAST=1.
- po_pkt_done: registered; high for the one cycle after each handshake with TLAST=1.
- FIFO occupancy: a FIFO write and a register load in the same cycle leave the count unchanged. Pointers wrap modulo C_FIFO_DEPTH.
- Capacity: C_FIFO_DEPTH words in the FIFO plus 1 in the output register. po_mlp_ready reflects the FIFO only.

Decomposition:
- Package mlp_axis_pkg holds:
  - C_M_AXIS_TDATA_WIDTH default and the derived strobe width;
  - typedef mlp_word_t;
  - function clog2_min1 for pointer and counter widths.
- Sub-module sync_fifo:
  - Parameters: width and depth.
  - Ports: wr_en/din, rd_en/dout (first-word-fall-through), full, empty, count.
  - Same clock and synchronous active-high reset.
- The top level holds the output register, beat counter and status flags.

Test Plan:
- Basic packet: after reset, write 10 words 0x3, 0xE, 0x19, … (step 0xB), TREADY=1 → 10 beats in order; TLAST only on the 10th (0x66); po_pkt_done pulses once; first TVALID two cycles after the first write.
- Backpressure: TREADY low for 5 cycles while TVALID=1 → TDATA and TLAST stable and TVALID held; the beat transfers on the first TREADY=1 edge; no words lost or duplicated.
- Full/overflow: TREADY=0, write 18 words → 17 accepted (16 FIFO plus 1 register); po_mlp_ready=0; the 18th is dropped and po_overflow=1; draining yields exactly the first 17 values.
- Streaming: continuous writes and TREADY=1 for 30 words → one beat per cycle after fill; TLAST on beats 10, 20 and 30; three po_pkt_done pulses.
- Random TREADY (50%) with random write gaps over 200 words → output matches the scoreboard order; TLAST every 10th beat; po_overflow=0 while writes respect po_mlp_ready.
- Reset mid-packet: after 4 beats of a packet, assert M_AXIS_ARESET for 1 cycle → TVALID=0 and FIFO empty; a new 10-word packet has TLAST on its own 10th beat.
